// File: rtl/flag_pkg.sv
// Shared types and defaults for the C/Z flag shadow stack.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package flag_pkg;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  localparam int FLAG_STACK_DEPTH_DEF = 4;

endpackage

// File: rtl/flag_stack_mem.sv
// Register array holding the stacked {c,z} pairs; no reset on contents.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none; the owner decides when a write is legal.
module flag_stack_mem
  import flag_pkg::*;
#(
  parameter int DEPTH = FLAG_STACK_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  flags_t        wr_dat_i,
  input  logic [AW-1:0] rd_addr_i,
  output flags_t        rd_dat_o
);

  flags_t mem_q [DEPTH];

  // Write the addressed slot; addresses beyond the array are never issued.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en_i && (wr_addr_i == AW'(i))) begin
        mem_q[i] <= wr_dat_i;
      end
    end
  end

  // Combinational read mux; an out-of-range address returns zeros.
  always_comb begin
    rd_dat_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_i == AW'(i)) begin
        rd_dat_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/flag_shadow_stack.sv
// LIFO saving C/Z on interrupt entry and replaying them on RETI with a restore strobe.
// Latency: push stored in 1 edge; pop produces restore/c_out/z_out 1 cycle later.
// Backpressure: none; push when full or pop when empty is dropped (flagged under FLAG_STACK_ERR_EN).
module flag_shadow_stack
  import flag_pkg::*;
#(
  parameter int DEPTH = FLAG_STACK_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       c_in,
  input  logic                       z_in,
  output logic                       c_out,
  output logic                       z_out,
  output logic                       restore,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int DW = $clog2(DEPTH + 1);

  logic [DW-1:0] depth_q, depth_d;
  logic          empty_q, full_q;
  logic          restore_q;
  flags_t        out_q;

  logic          do_pop, do_push;
  logic [DW-1:0] wr_addr, rd_addr;
  flags_t        wr_dat, rd_dat;

  assign wr_dat = '{c: c_in, z: z_in};

  // Decide which operations take effect and the next occupancy.
  always_comb begin
    do_pop  = pop & ~empty_q;
    // A push while full is only legal when the same cycle pops the top slot.
    do_push = push & (~full_q | do_pop);
    rd_addr = depth_q - DW'(1);
    // A simultaneous push/pop overwrites the slot that is being popped.
    wr_addr = do_pop ? rd_addr : depth_q;
    depth_d = depth_q;
    if (do_push && !do_pop) begin
      depth_d = depth_q + DW'(1);
    end else if (do_pop && !do_push) begin
      depth_d = depth_q - DW'(1);
    end
  end

  flag_stack_mem #(
    .DEPTH (DEPTH),
    .AW    (DW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (do_push),
    .wr_addr_i (wr_addr),
    .wr_dat_i  (wr_dat),
    .rd_addr_i (rd_addr),
    .rd_dat_o  (rd_dat)
  );

  // Occupancy, status and restore output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      depth_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      restore_q <= 1'b0;
      out_q     <= '0;
    end else begin
      depth_q   <= depth_d;
      empty_q   <= (depth_d == '0);
      full_q    <= (depth_d == DW'(DEPTH));
      restore_q <= do_pop;
      if (do_pop) begin
        out_q <= rd_dat;
      end
    end
  end

  assign depth   = depth_q;
  assign empty   = empty_q;
  assign full    = full_q;
  assign restore = restore_q;
  assign c_out   = out_q.c;
  assign z_out   = out_q.z;

`ifdef FLAG_STACK_ERR_EN
  logic ovf_q, unf_q;
  logic ovf_evt, unf_evt;

  assign ovf_evt = push & ~pop & full_q;
  assign unf_evt = pop & empty_q;

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_evt | (ovf_q & ~err_clr);
      unf_q <= unf_evt | (unf_q & ~err_clr);
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_flag_shadow_stack.sv
module tb_flag_shadow_stack;

  logic       clk = 1'b0;
  logic       reset_n, push, pop, c_in, z_in, err_clr;
  logic       c_out, z_out, restore, empty, full, overflow, underflow;
  logic [2:0] depth;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flag_shadow_stack #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .c_in      (c_in),
    .z_in      (z_in),
    .c_out     (c_out),
    .z_out     (z_out),
    .restore   (restore),
    .depth     (depth),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .err_clr   (err_clr)
  );

  typedef struct {
    logic       rst_n, psh, pp, c, z, clr;
    logic       rs, co, zo;
    logic [2:0] dep;
    logic       emp, ful, ovf, unf;
  } vec_t;

  vec_t vecs[$];

  // Error flags only exist when the feature is compiled in.
  function automatic logic ef(input logic v);
`ifdef FLAG_STACK_ERR_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  function automatic vec_t mk(input logic rst_n, psh, pp, c, z, clr,
                              input logic rs, co, zo, input int dep,
                              input logic emp, ful, ovf, unf);
    vec_t v;
    v.rst_n = rst_n; v.psh = psh; v.pp = pp; v.c = c; v.z = z; v.clr = clr;
    v.rs = rs; v.co = co; v.zo = zo; v.dep = 3'(dep);
    v.emp = emp; v.ful = ful; v.ovf = ef(ovf); v.unf = ef(unf);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, psh, pp, c, z, clr);
    reset_n = rst_n; push = psh; pop = pp; c_in = c; z_in = z; err_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    //             rst psh pop c z clr   rs co zo dep emp ful ovf unf
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0)); // 0 reset
    vecs.push_back(mk(1, 1, 0, 1, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0)); // 1 push 10
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 1, 0, 0,  1, 0, 0, 0)); // 2 pop
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 0,  1, 0, 0, 0)); // 3 hold
    vecs.push_back(mk(1, 1, 0, 0, 1, 0,  0, 1, 0, 1,  0, 0, 0, 0)); // 4 push 01
    vecs.push_back(mk(1, 1, 0, 1, 1, 0,  0, 1, 0, 2,  0, 0, 0, 0)); // 5 push 11
    vecs.push_back(mk(1, 1, 0, 1, 0, 0,  0, 1, 0, 3,  0, 0, 0, 0)); // 6 push 10
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  0, 1, 0, 4,  0, 1, 0, 0)); // 7 push 00 full
    vecs.push_back(mk(1, 1, 0, 1, 1, 0,  0, 1, 0, 4,  0, 1, 1, 0)); // 8 overflow
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 0, 0, 3,  0, 0, 1, 0)); // 9 pop 00
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 1, 0, 2,  0, 0, 1, 0)); // 10 pop 10
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 1, 1, 1,  0, 0, 1, 0)); // 11 pop 11
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 0, 1, 0,  1, 0, 1, 0)); // 12 pop 01
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  0, 0, 1, 0,  1, 0, 1, 1)); // 13 underflow
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  0, 0, 1, 0,  1, 0, 0, 0)); // 14 err_clr
    vecs.push_back(mk(1, 1, 0, 0, 1, 0,  0, 0, 1, 1,  0, 0, 0, 0)); // 15 push 01
    vecs.push_back(mk(1, 1, 0, 1, 1, 0,  0, 0, 1, 2,  0, 0, 0, 0)); // 16 push 11
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,  1, 1, 1, 2,  0, 0, 0, 0)); // 17 push00+pop
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 0, 0, 1,  0, 0, 0, 0)); // 18 pop 00
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 0, 1, 0,  1, 0, 0, 0)); // 19 pop 01
    vecs.push_back(mk(1, 1, 0, 1, 0, 0,  0, 0, 1, 1,  0, 0, 0, 0)); // 20 push 10
    vecs.push_back(mk(1, 1, 0, 0, 1, 0,  0, 0, 1, 2,  0, 0, 0, 0)); // 21 push 01
    vecs.push_back(mk(1, 1, 0, 1, 1, 0,  0, 0, 1, 3,  0, 0, 0, 0)); // 22 push 11
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0, 1, 4,  0, 1, 0, 0)); // 23 push 00 full
    vecs.push_back(mk(1, 1, 1, 1, 1, 0,  1, 0, 0, 4,  0, 1, 0, 0)); // 24 push11+pop full
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 1, 1, 3,  0, 0, 0, 0)); // 25 pop 11 (replaced)
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 1, 1, 2,  0, 0, 0, 0)); // 26 pop 11
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 0, 1, 1,  0, 0, 0, 0)); // 27 pop 01
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 1, 0, 0,  1, 0, 0, 0)); // 28 pop 10
    vecs.push_back(mk(1, 1, 1, 0, 1, 0,  0, 1, 0, 1,  0, 0, 0, 1)); // 29 push01+pop empty
    vecs.push_back(mk(1, 0, 1, 0, 0, 1,  1, 0, 1, 0,  1, 0, 0, 0)); // 30 clr + legal pop
    vecs.push_back(mk(1, 0, 1, 0, 0, 1,  0, 0, 1, 0,  1, 0, 0, 1)); // 31 clr + new error
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  0, 0, 1, 0,  1, 0, 0, 0)); // 32 clr
    vecs.push_back(mk(1, 1, 0, 1, 1, 0,  0, 0, 1, 1,  0, 0, 0, 0)); // 33 push 11
    vecs.push_back(mk(1, 1, 0, 1, 0, 0,  0, 0, 1, 2,  0, 0, 0, 0)); // 34 push 10
    vecs.push_back(mk(1, 1, 0, 0, 1, 0,  0, 0, 1, 3,  0, 0, 0, 0)); // 35 push 01
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0)); // 36 pop under reset
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 1)); // 37 pop -> underflow
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  0, 0, 0, 0,  1, 0, 0, 0)); // 38 clr

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].psh, vecs[i].pp, vecs[i].c, vecs[i].z, vecs[i].clr);
      step();
      check("restore",   i, int'(restore),   int'(vecs[i].rs));
      check("c_out",     i, int'(c_out),     int'(vecs[i].co));
      check("z_out",     i, int'(z_out),     int'(vecs[i].zo));
      check("depth",     i, int'(depth),     int'(vecs[i].dep));
      check("empty",     i, int'(empty),     int'(vecs[i].emp));
      check("full",      i, int'(full),      int'(vecs[i].ful));
      check("overflow",  i, int'(overflow),  int'(vecs[i].ovf));
      check("underflow", i, int'(underflow), int'(vecs[i].unf));
    end

    // Overflow arriving in the same cycle as err_clr keeps the flag set.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'(i & 1), 1'(i >> 1), 1'b0);
      step();
    end
    check("fill_full", 100, int'(full), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("ovf_clr_race", 101, int'(overflow), int'(ef(1'b1)));
    check("ovf_depth", 102, int'(depth), 4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("ovf_cleared", 103, int'(overflow), 0);

    // A single pop yields exactly one restore pulse with the newest entry {1,1}.
    begin
      int pulses;
      int first_cyc;
      pulses = 0;
      first_cyc = -1;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (restore) begin
          pulses++;
          if (first_cyc < 0) begin
            first_cyc = k;
            check("pulse_c", 104, int'(c_out), 1);
            check("pulse_z", 105, int'(z_out), 1);
          end
        end
      end
      check("pulse_count", 106, pulses, 1);
      check("pulse_latency", 107, first_cyc, 0);
      check("pulse_depth", 108, int'(depth), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
